// File: rtl/dmem_io_ctrl.sv
// Data RAM plus memory-mapped I/O page for the LEGLite CPU data port:
// debounced switches with sticky rise flags, hex 7-segment digits and a cycle counter.
module dmem_io_ctrl #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int DEPTH    = 128,
   parameter int NUM_SW   = 2,
   parameter int NUM_DISP = 2,
   parameter int DEBOUNCE = 4,
   parameter logic [ADDR_W-9:0] IO_PAGE = 8'hFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     draddr,
   input  logic [DATA_W-1:0]     dwdata,
   input  logic                  dwrite,
   input  logic                  dread,
   input  logic [NUM_SW-1:0]     io_sw,
   output logic [DATA_W-1:0]     drdata,
   output logic [7*NUM_DISP-1:0] io_display
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] seg;
      case (v)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return seg;
   endfunction

   logic              is_io;
   logic [6:0]        io_word;
   logic [AW-1:0]     ram_idx;
   logic              wr_io;
   logic              wr_rise;
   logic              wr_cyc;
   logic              unused_addr0;

   // Byte address bit 0 never selects anything; offsets are compared as word indices.
   assign is_io        = (draddr[ADDR_W-1:8] == IO_PAGE);
   assign io_word      = draddr[7:1];
   assign ram_idx      = draddr[AW:1];
   assign wr_io        = dwrite & is_io;
   assign wr_rise      = wr_io & (io_word == 7'd1);
   assign wr_cyc       = wr_io & (io_word == 7'd2);
   assign unused_addr0 = draddr[0];

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (dwrite && !is_io) mem[ram_idx] <= dwdata;
   end

   logic [NUM_SW-1:0] sync1;
   logic [NUM_SW-1:0] sync_s;
   logic [NUM_SW-1:0] deb;
   logic [NUM_SW-1:0] rise;
   logic [NUM_SW-1:0] accept;
   logic [NUM_SW-1:0] rise_set;
   logic [NUM_SW-1:0] rise_clr;
   logic [NUM_SW-1:0] rise_next;
   logic [CW-1:0]     cnt [NUM_SW];

   always_comb begin
      for (int i = 0; i < NUM_SW; i++) begin
         accept[i] = (sync_s[i] != deb[i]) && (cnt[i] == CW'(DEBOUNCE - 1));
      end
      rise_set  = accept & sync_s;
      rise_clr  = wr_rise ? dwdata[NUM_SW-1:0] : '0;
      // A rise accepted on the same edge as a W1C clear survives.
      rise_next = (rise & ~rise_clr) | rise_set;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1  <= '0;
         sync_s <= '0;
         deb    <= '0;
         rise   <= '0;
         for (int i = 0; i < NUM_SW; i++) cnt[i] <= '0;
      end else begin
         sync1  <= io_sw;
         sync_s <= sync1;
         rise   <= rise_next;
         for (int i = 0; i < NUM_SW; i++) begin
            if (sync_s[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (accept[i]) begin
               deb[i] <= sync_s[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   logic [DATA_W-1:0] cyc;

   always_ff @(posedge clock) begin
      if (reset || wr_cyc) cyc <= '0;
      else                 cyc <= cyc + DATA_W'(1);
   end

   logic [3:0] disp      [NUM_DISP];
   logic [3:0] disp_next [NUM_DISP];

   always_comb begin
      for (int i = 0; i < NUM_DISP; i++) begin
         disp_next[i] = disp[i];
         if (wr_io && (io_word == 7'(8 + i))) disp_next[i] = dwdata[3:0];
      end
   end

   // Segments decode the next register value so a write shows on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_DISP; i++) begin
            disp[i]              <= '0;
            io_display[7*i +: 7] <= 7'h3F;
         end
      end else begin
         for (int i = 0; i < NUM_DISP; i++) begin
            disp[i]              <= disp_next[i];
            io_display[7*i +: 7] <= hex7(disp_next[i]);
         end
      end
   end

   logic [DATA_W-1:0] io_val;

   always_comb begin
      io_val = '0;
      case (io_word)
         7'd0:    io_val[NUM_SW-1:0] = deb;
         7'd1:    io_val[NUM_SW-1:0] = rise;
         7'd2:    io_val             = cyc;
         default: begin
            for (int i = 0; i < NUM_DISP; i++) begin
               if (io_word == 7'(8 + i)) io_val[3:0] = disp[i];
            end
         end
      endcase
      drdata = '0;
      if (dread) drdata = is_io ? io_val : mem[ram_idx];
   end

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Self-checking bench for dmem_io_ctrl: RAM, debounce, W1C race, display,
// cycle counter and reset during debounce.
module tb_dmem_io_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] draddr = '0;
   logic [15:0] dwdata = '0;
   logic        dwrite = 1'b0;
   logic        dread = 1'b0;
   logic [1:0]  io_sw = '0;
   logic [15:0] drdata;
   logic [13:0] io_display;

   logic [15:0] exp_q[$];
   int          passed = 0;
   int          total = 0;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   dmem_io_ctrl dut (
      .clock(clock),
      .reset(reset),
      .draddr(draddr),
      .dwdata(dwdata),
      .dwrite(dwrite),
      .dread(dread),
      .io_sw(io_sw),
      .drdata(drdata),
      .io_display(io_display)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      draddr = a;
      dread  = 1'b1;
      #1;
      d      = drdata;
      dread  = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      draddr = a;
      dwdata = d;
      dwrite = 1'b1;
      dread  = 1'b0;
      step();
      dwrite = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] got, exp;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      total++;
      if (io_display !== {7'h3F, 7'h3F}) $display("FAIL reset_display got=%h exp=%h", io_display, {7'h3F, 7'h3F});
      else passed++;
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0000);
      rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_sw_level got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_sw_rise got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF10, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL reset_disp0 got=%h exp=%h", got, exp); else passed++;
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back(16'(k));
         rd(16'hFF04, got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL reset_cyc got=%h exp=%h", got, exp); else passed++;
         step();
      end
   endtask

   task automatic test_ram();
      logic [15:0] got, exp, d;
      wr(16'h0006, 16'hBEEF);
      exp_q.push_back(16'hBEEF);
      rd(16'h0006, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL ram_read got=%h exp=%h", got, exp); else passed++;
      exp_q.push_back(16'hBEEF);
      rd(16'h0106, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL ram_alias got=%h exp=%h", got, exp); else passed++;
      draddr = 16'h0006;
      dread  = 1'b0;
      #1;
      total++;
      if (drdata !== 16'h0000) $display("FAIL ram_dread0 got=%h exp=%h", drdata, 16'h0000); else passed++;
      // Read and write the same word in one cycle: old data visible until the edge.
      dread  = 1'b1;
      dwrite = 1'b1;
      dwdata = 16'h1111;
      #1;
      total++;
      if (drdata !== 16'hBEEF) $display("FAIL ram_rw_old got=%h exp=%h", drdata, 16'hBEEF); else passed++;
      step();
      dwrite = 1'b0;
      total++;
      if (drdata !== 16'h1111) $display("FAIL ram_rw_new got=%h exp=%h", drdata, 16'h1111); else passed++;
      dread = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = 16'($urandom_range(0, 16'hFFFF));
         exp_q.push_back(d);
         wr(16'h0040 + 16'(2 * i), d);
      end
      for (int i = 0; i < 4; i++) begin
         rd(16'h0040 + 16'(2 * i), got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL ram_random got=%h exp=%h", got, exp); else passed++;
      end
   endtask

   task automatic test_debounce();
      logic [15:0] got, exp;
      io_sw[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         exp_q.push_back((k >= 6) ? 16'h0001 : 16'h0000);
         rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL deb_level edge=%0d got=%h exp=%h", k, got, exp); else passed++;
         if (k >= 5) begin
            exp_q.push_back((k >= 6) ? 16'h0001 : 16'h0000);
            rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
            if (got !== exp) $display("FAIL deb_rise edge=%0d got=%h exp=%h", k, got, exp); else passed++;
         end
      end
      io_sw[1] = 1'b1;
      step();
      step();
      step();
      io_sw[1] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         exp_q.push_back(16'h0001);
         rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL glitch_level got=%h exp=%h", got, exp); else passed++;
      end
      exp_q.push_back(16'h0001);
      rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL glitch_rise got=%h exp=%h", got, exp); else passed++;
   endtask

   task automatic test_w1c_race();
      logic [15:0] got, exp;
      io_sw[1] = 1'b1;
      for (int k = 1; k <= 5; k++) step();
      wr(16'hFF02, 16'h0003);
      exp_q.push_back(16'h0002);
      exp_q.push_back(16'h0003);
      rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL race_rise got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL race_level got=%h exp=%h", got, exp); else passed++;
      wr(16'hFF02, 16'h0002);
      exp_q.push_back(16'h0000);
      rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL w1c_clear got=%h exp=%h", got, exp); else passed++;
   endtask

   task automatic test_display();
      logic [15:0] got, exp;
      logic [3:0]  v;
      wr(16'hFF10, 16'h00A7);
      total++;
      if (io_display[6:0] !== 7'h07) $display("FAIL disp0_seg got=%h exp=%h", io_display[6:0], 7'h07); else passed++;
      wr(16'hFF12, 16'h0003);
      total++;
      if (io_display !== {7'h4F, 7'h07}) $display("FAIL disp_both got=%h exp=%h", io_display, {7'h4F, 7'h07}); else passed++;
      wr(16'hFF00, 16'hFFFF);
      exp_q.push_back(16'h0007);
      exp_q.push_back(16'h0003);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0003);
      rd(16'hFF10, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL disp0_read got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF12, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL disp1_read got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF06, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL io_unmapped got=%h exp=%h", got, exp); else passed++;
      rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL level_ro got=%h exp=%h", got, exp); else passed++;
      for (int i = 0; i < 6; i++) begin
         v = 4'($urandom_range(0, 15));
         wr(16'hFF12, {12'($urandom_range(0, 12'hFFF)), v});
         total++;
         if (io_display[13:7] !== seg_tab[v]) $display("FAIL disp1_seg val=%h got=%h exp=%h", v, io_display[13:7], seg_tab[v]);
         else passed++;
      end
   endtask

   task automatic test_counter();
      logic [15:0] got, exp;
      wr(16'hFF04, 16'h1234);
      exp_q.push_back(16'h0000);
      rd(16'hFF04, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL cyc_clear got=%h exp=%h", got, exp); else passed++;
      step();
      exp_q.push_back(16'h0001);
      rd(16'hFF04, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL cyc_inc got=%h exp=%h", got, exp); else passed++;
      wr(16'hFF04, 16'h0000);
      repeat (65535) step();
      exp_q.push_back(16'hFFFF);
      rd(16'hFF04, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL cyc_max got=%h exp=%h", got, exp); else passed++;
      step();
      exp_q.push_back(16'h0000);
      rd(16'hFF04, got); exp = exp_q.pop_front(); total++;
      if (got !== exp) $display("FAIL cyc_wrap got=%h exp=%h", got, exp); else passed++;
   endtask

   task automatic test_reset_mid_debounce();
      logic [15:0] got, exp;
      io_sw = 2'b00;
      step();
      step();
      step();
      io_sw = 2'b11;
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      total++;
      if (io_display !== {7'h3F, 7'h3F}) $display("FAIL rst2_display got=%h exp=%h", io_display, {7'h3F, 7'h3F});
      else passed++;
      for (int k = 1; k <= 6; k++) begin
         step();
         exp_q.push_back((k >= 6) ? 16'h0003 : 16'h0000);
         exp_q.push_back((k >= 6) ? 16'h0003 : 16'h0000);
         rd(16'hFF00, got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL rst2_level edge=%0d got=%h exp=%h", k, got, exp); else passed++;
         rd(16'hFF02, got); exp = exp_q.pop_front(); total++;
         if (got !== exp) $display("FAIL rst2_rise edge=%0d got=%h exp=%h", k, got, exp); else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_ram();
      test_debounce();
      test_w1c_race();
      test_display();
      test_counter();
      test_reset_mid_debounce();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
